// File: rtl/pc_loop_monitor.sv
// Infinite-loop detector: records fetch PCs in a circular history and flags a loop
// once THRESH consecutive valid samples each match an earlier history entry.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | history empty (fill_level = 0)
// S_FILL   | history partially filled (0 < fill_level < DEPTH)
// S_FULL   | history full, oldest entry overwritten per sample
// S_LOCKED | loop declared; everything frozen until clear/reset
module pc_loop_monitor #(
  parameter int PC_W   = 32,
  parameter int DEPTH  = 11,
  parameter int THRESH = 11,
  localparam int RUN_W  = $clog2(THRESH + 1),
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  input  logic              pc_valid,
  input  logic              clear,
  output logic              loop_detect,
  output logic              halt_req,
  output logic [PC_W-1:0]   loop_pc,
  output logic [RUN_W-1:0]  run_count,
  output logic [FILL_W-1:0] fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [FILL_W-1:0] FULL_V   = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  localparam logic [RUN_W:0]    THRESH_V = (RUN_W + 1)'(THRESH);
  localparam logic [RUN_W:0]    RUN_ONE  = (RUN_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_FULL   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]   hist [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic              hit;
  logic              sample;
  logic              detect;
  logic [RUN_W:0]    run_inc;
  logic [FILL_W-1:0] fill_nxt;

  // Hit is judged against the history as it stood before this edge's write.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (hist[i] == pc)) hit = 1'b1;
    end
  end

  assign sample   = pc_valid && !clear && (state != S_LOCKED);
  assign run_inc  = {1'b0, run_count} + RUN_ONE;
  assign detect   = sample && hit && (run_inc == THRESH_V);
  assign fill_nxt = (fill_level == FULL_V) ? fill_level : fill_level + FILL_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else if (sample) begin
      if (detect)                  state_nxt = S_LOCKED;
      else if (fill_nxt == FULL_V) state_nxt = S_FULL;
      else                         state_nxt = S_FILL;
    end
  end

  always_comb begin
    loop_detect = (state == S_LOCKED);
  end

  // Entry contents need no reset: the valid bits gate every comparison.
  always_ff @(posedge clk) begin
    if (sample) hist[wr_ptr] <= pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= '0;
      wr_ptr     <= '0;
      run_count  <= '0;
      fill_level <= '0;
      loop_pc    <= '0;
      halt_req   <= 1'b0;
    end else if (clear) begin
      valid      <= '0;
      wr_ptr     <= '0;
      run_count  <= '0;
      fill_level <= '0;
      loop_pc    <= '0;
      halt_req   <= 1'b0;
    end else begin
      halt_req <= 1'b0;
      if (sample) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
        run_count     <= hit ? run_inc[RUN_W-1:0] : '0;
        fill_level    <= fill_nxt;
        if (detect) begin
          halt_req <= 1'b1;
          loop_pc  <= pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_loop_monitor.sv
// Scenario bench for pc_loop_monitor against a queue-based history model.
module tb_pc_loop_monitor;

  localparam int PC_W   = 32;
  localparam int DEPTH  = 11;
  localparam int THRESH = 11;
  localparam int RUN_W  = $clog2(THRESH + 1);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int VEC_W  = 2 + PC_W + RUN_W + FILL_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC_W-1:0]   pc;
  logic              pc_valid;
  logic              clear;
  logic              loop_detect;
  logic              halt_req;
  logic [PC_W-1:0]   loop_pc;
  logic [RUN_W-1:0]  run_count;
  logic [FILL_W-1:0] fill_level;

  pc_loop_monitor #(.PC_W(PC_W), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .clear       (clear),
    .loop_detect (loop_detect),
    .halt_req    (halt_req),
    .loop_pc     (loop_pc),
    .run_count   (run_count),
    .fill_level  (fill_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PC_W-1:0] m_hist [$];
  int              m_run;
  logic            m_locked;
  logic            m_halt;
  logic [PC_W-1:0] m_lpc;

  wire [VEC_W-1:0] dut_vec = {loop_detect, halt_req, loop_pc, run_count, fill_level};

  function automatic void model_clear();
    m_hist.delete();
    m_run    = 0;
    m_locked = 1'b0;
    m_halt   = 1'b0;
    m_lpc    = '0;
  endfunction

  function automatic logic [VEC_W-1:0] model_vec();
    return {m_locked, m_halt, m_lpc, RUN_W'(m_run), FILL_W'(m_hist.size())};
  endfunction

  // Drive one cycle at the falling edge, advance the model at the rising edge,
  // return at the next falling edge where outputs are sampled.
  task automatic step(input logic [PC_W-1:0] p, input logic v, input logic c);
    bit h;
    pc = p; pc_valid = v; clear = c;
    @(posedge clk);
    if (c) begin
      model_clear();
    end else begin
      m_halt = 1'b0;
      if (v && !m_locked) begin
        h = 0;
        foreach (m_hist[i]) if (m_hist[i] == p) h = 1;
        m_run = h ? m_run + 1 : 0;
        m_hist.push_back(p);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
        if (m_run == THRESH) begin
          m_locked = 1'b1;
          m_halt   = 1'b1;
          m_lpc    = p;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = '0; pc_valid = 1'b0; clear = 1'b0;
    model_clear();
    #3;
    n_tests++;
    if (dut_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", dut_vec);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_straight_line();
    step('0, 1'b0, 1'b1);
    for (int k = 0; k <= 64; k++) begin
      step(PC_W'(k * 4), 1'b1, 1'b0);
      n_tests++;
      if (dut_vec !== model_vec() || run_count !== '0 || loop_detect !== 1'b0) begin
        n_fail++;
        $display("FAIL straight_line k=%0d: got %h expected %h", k, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (fill_level !== FILL_W'(DEPTH)) begin
      n_fail++;
      $display("FAIL straight_fill_sat: got %0d expected %0d", fill_level, DEPTH);
    end
  endtask

  task automatic test_self_loop();
    step('0, 1'b0, 1'b1);
    for (int s = 1; s <= 12; s++) begin
      step(32'h20, 1'b1, 1'b0);
      n_tests++;
      if (dut_vec !== model_vec() || run_count !== RUN_W'(s - 1) ||
          loop_detect !== (s == 12) || halt_req !== (s == 12)) begin
        n_fail++;
        $display("FAIL self_loop s=%0d: got %h expected %h", s, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (loop_pc !== 32'h20) begin
      n_fail++;
      $display("FAIL self_loop_pc: got %h expected 00000020", loop_pc);
    end
    for (int s = 0; s < 3; s++) begin
      step(32'h20 + PC_W'(s * 4), 1'b1, 1'b0);
      n_tests++;
      if (halt_req !== 1'b0 || loop_detect !== 1'b1 || run_count !== RUN_W'(THRESH) ||
          fill_level !== FILL_W'(DEPTH) || loop_pc !== 32'h20) begin
        n_fail++;
        $display("FAIL locked_frozen s=%0d: got %h expected %h", s, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_two_instr();
    step('0, 1'b0, 1'b1);
    for (int s = 1; s <= 13; s++) begin
      step((s % 2 == 1) ? 32'h40 : 32'h44, 1'b1, 1'b0);
      n_tests++;
      if (dut_vec !== model_vec() || loop_detect !== (s == 13) ||
          run_count !== RUN_W'((s <= 2) ? 0 : s - 2)) begin
        n_fail++;
        $display("FAIL two_instr s=%0d: got %h expected %h", s, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (loop_pc !== 32'h40 || halt_req !== 1'b1) begin
      n_fail++;
      $display("FAIL two_instr_pc: got pc=%h halt=%b expected pc=00000040 halt=1", loop_pc, halt_req);
    end
  endtask

  task automatic test_stall_loop();
    int nv = 0;
    step('0, 1'b0, 1'b1);
    for (int c = 0; c < 24; c++) begin
      if (c % 2 == 0) nv++;
      step(32'h20, (c % 2 == 0), 1'b0);
      n_tests++;
      if (dut_vec !== model_vec() || loop_detect !== (nv >= 12)) begin
        n_fail++;
        $display("FAIL stall_loop c=%0d: got %h expected %h", c, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_clear();
    step('0, 1'b0, 1'b1);
    for (int s = 0; s < 6; s++) step(32'h20, 1'b1, 1'b0);
    n_tests++;
    if (run_count !== RUN_W'(5) || fill_level !== FILL_W'(6)) begin
      n_fail++;
      $display("FAIL clear_pre: got run=%0d fill=%0d expected run=5 fill=6", run_count, fill_level);
    end
    step(32'h20, 1'b1, 1'b1);
    n_tests++;
    if (dut_vec !== '0) begin
      n_fail++;
      $display("FAIL clear_priority: got %h expected 0", dut_vec);
    end
    for (int s = 1; s <= 12; s++) begin
      step(32'h20, 1'b1, 1'b0);
      n_tests++;
      if (dut_vec !== model_vec() || loop_detect !== (s == 12)) begin
        n_fail++;
        $display("FAIL clear_relock s=%0d: got %h expected %h", s, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    step('0, 1'b0, 1'b1);
    for (int s = 0; s < 12; s++) step(32'h20, 1'b1, 1'b0);
    n_tests++;
    if (loop_detect !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_lock: got %b expected 1", loop_detect);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (dut_vec !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", dut_vec);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [PC_W-1:0] p;
    logic            v, c;
    int              locked_cycles = 0;
    for (int n = 0; n < 800; n++) begin
      p = PC_W'($urandom_range(0, 9) * 4);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 59) == 0) || (locked_cycles > 3);
      locked_cycles = m_locked ? locked_cycles + 1 : 0;
      step(p, v, c);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random n=%0d: got %h expected %h", n, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_self_loop();
    test_two_instr();
    test_stall_loop();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
